// File: rtl/soc_bus_pkg.sv
// Shared types and width helpers for the SoC memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package soc_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } arb_state_e;

  // Index/counter width that never collapses to zero bits for n == 1.
  function automatic int width_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner search starting one past the previous winner, wrapping.
// Latency: purely combinational.
// Backpressure: none; it only looks at the current request vector.
module rr_pick #(
  parameter int N  = 2,
  parameter int GW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] last,
  output logic [GW-1:0] winner,
  output logic          found
);

  logic [GW-1:0] idx;

  // Walk offsets 1..N from last so the previous winner has lowest priority.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= N; k++) begin
      idx = GW'((int'(last) + k) % N);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/soc_mem_arbiter.sv
// Round-robin arbiter putting NUM_MASTERS request channels onto one fixed-latency memory port.
// Latency: m_en one cycle after a request is seen in IDLE; ack LATENCY+2 cycles after that cycle.
// Backpressure: one transfer in flight; losers hold req and are sampled again in the next IDLE.
module soc_mem_arbiter
  import soc_bus_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int LATENCY     = 1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_MASTERS-1:0]                req,
  input  logic [NUM_MASTERS-1:0]                we,
  input  logic [NUM_MASTERS*ADDR_W-1:0]         addr,
  input  logic [NUM_MASTERS*DATA_W-1:0]         wdata,
  output logic [NUM_MASTERS-1:0]                ack,
  output logic [DATA_W-1:0]                     rdata,
  output logic                                  busy,
  output logic [width_min1(NUM_MASTERS)-1:0]    grant_id,
  output logic                                  m_en,
  output logic                                  m_we,
  output logic [ADDR_W-1:0]                     m_addr,
  output logic [DATA_W-1:0]                     m_wdata,
  input  logic [DATA_W-1:0]                     m_rdata
);

  localparam int GW = width_min1(NUM_MASTERS);
  localparam int CW = width_min1(LATENCY);

  arb_state_e             state_q, state_d;
  logic [GW-1:0]          last_q, last_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [NUM_MASTERS-1:0] ack_q, ack_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;
  logic                   busy_q, busy_d;
  logic [GW-1:0]          grant_q, grant_d;
  logic                   m_en_q, m_en_d;
  logic                   m_we_q, m_we_d;
  logic [ADDR_W-1:0]      m_addr_q, m_addr_d;
  logic [DATA_W-1:0]      m_wdata_q, m_wdata_d;

  logic [GW-1:0]          pick_idx;
  logic                   pick_found;

  rr_pick #(
    .N  (NUM_MASTERS),
    .GW (GW)
  ) u_rr_pick (
    .req    (req),
    .last   (last_q),
    .winner (pick_idx),
    .found  (pick_found)
  );

  // Next-state and registered-output logic; m_en and ack default to idle pulses.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    ack_d     = '0;
    rdata_d   = rdata_q;
    grant_d   = grant_q;
    m_en_d    = 1'b0;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          m_en_d    = 1'b1;
          m_we_d    = we[pick_idx];
          m_addr_d  = addr[int'(pick_idx)*ADDR_W +: ADDR_W];
          m_wdata_d = wdata[int'(pick_idx)*DATA_W +: DATA_W];
          grant_d   = pick_idx;
          last_d    = pick_idx;
          cnt_d     = CW'(LATENCY - 1);
          state_d   = WAIT;
        end
      end
      WAIT: begin
        // The strobe cycle itself does not count; memory data lands LATENCY cycles after it.
        if (!m_en_q) begin
          if (cnt_q == '0) begin
            if (!m_we_q) begin
              rdata_d = m_rdata;
            end
            ack_d   = NUM_MASTERS'(1) << grant_q;
            state_d = ACK;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset aborts any transfer in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      last_q    <= GW'(NUM_MASTERS - 1);
      cnt_q     <= '0;
      ack_q     <= '0;
      rdata_q   <= '0;
      busy_q    <= 1'b0;
      grant_q   <= '0;
      m_en_q    <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      busy_q    <= busy_d;
      grant_q   <= grant_d;
      m_en_q    <= m_en_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
    end
  end

  assign ack      = ack_q;
  assign rdata    = rdata_q;
  assign busy     = busy_q;
  assign grant_id = grant_q;
  assign m_en     = m_en_q;
  assign m_we     = m_we_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;

endmodule

// File: tb/tb_soc_mem_arbiter.sv
// Bench for soc_mem_arbiter: a 2-channel/latency-1 instance and a 3-channel/latency-4 instance.
// Latency: checks exact cycle positions of m_en and ack against the request cycle.
// Backpressure: masters hold requests until ack, as the arbiter expects.
`timescale 1ns/1ps
module tb_soc_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NA = 2;
  localparam int LA = 1;
  localparam int NB = 3;
  localparam int LB = 4;

  typedef struct {
    logic [2:0]  ack;
    logic [31:0] rdata;
    int          lat;
    int          gid;
  } exp_t;

  typedef struct {
    bit          ok;
    int          men_cnt;
    int          men_cyc;
    logic [31:0] madr;
    logic [31:0] mwd;
    logic        mwe;
    int          gid;
    int          ack_cyc;
    logic [2:0]  ack;
    logic [31:0] rdata;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  exp_t exp_q_a[$];
  exp_t exp_q_b[$];

  // DUT A: 2 channels, latency 1
  logic             rst_a;
  logic [NA-1:0]    req_a, we_a, ack_a;
  logic [NA*AW-1:0] addr_a;
  logic [NA*DW-1:0] wdata_a;
  logic [DW-1:0]    rdata_a, maddr_a, mwdata_a, mrdata_a;
  logic             busy_a, men_a, mwe_a;
  logic [0:0]       gid_a;

  soc_mem_arbiter #(.NUM_MASTERS(NA), .ADDR_W(AW), .DATA_W(DW), .LATENCY(LA)) dut_a (
    .clk(clk), .reset(rst_a), .req(req_a), .we(we_a), .addr(addr_a), .wdata(wdata_a),
    .ack(ack_a), .rdata(rdata_a), .busy(busy_a), .grant_id(gid_a),
    .m_en(men_a), .m_we(mwe_a), .m_addr(maddr_a), .m_wdata(mwdata_a), .m_rdata(mrdata_a)
  );

  // DUT B: 3 channels, latency 4
  logic             rst_b;
  logic [NB-1:0]    req_b, we_b, ack_b;
  logic [NB*AW-1:0] addr_b;
  logic [NB*DW-1:0] wdata_b;
  logic [DW-1:0]    rdata_b, maddr_b, mwdata_b, mrdata_b;
  logic             busy_b, men_b, mwe_b;
  logic [1:0]       gid_b;

  soc_mem_arbiter #(.NUM_MASTERS(NB), .ADDR_W(AW), .DATA_W(DW), .LATENCY(LB)) dut_b (
    .clk(clk), .reset(rst_b), .req(req_b), .we(we_b), .addr(addr_b), .wdata(wdata_b),
    .ack(ack_b), .rdata(rdata_b), .busy(busy_b), .grant_id(gid_b),
    .m_en(men_b), .m_we(mwe_b), .m_addr(maddr_b), .m_wdata(mwdata_b), .m_rdata(mrdata_b)
  );

  // Memory model: data for an address appears exactly LATENCY cycles after m_en, garbage otherwise.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a - 32'h40) ^ 32'hDEAD_BEEF;
  endfunction

  logic [31:0] pipe_a [LA];
  logic [31:0] pipe_b [LB];

  always @(posedge clk) begin
    pipe_a[0] <= men_a ? mem_fn(maddr_a) : 32'hBAD0_0BAD;
    for (int i = 1; i < LA; i++) pipe_a[i] <= pipe_a[i-1];
    pipe_b[0] <= men_b ? mem_fn(maddr_b) : 32'hBAD0_0BAD;
    for (int i = 1; i < LB; i++) pipe_b[i] <= pipe_b[i-1];
  end

  assign mrdata_a = pipe_a[LA-1];
  assign mrdata_b = pipe_b[LB-1];

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  // Observe DUT A from the next cycle until ack (bounded), recording the m_en cycle.
  task automatic wait_a(output obs_t o);
    o = '{default: 0};
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (men_a) begin
        o.men_cnt++; o.men_cyc = cyc; o.madr = maddr_a; o.mwe = mwe_a;
        o.mwd = mwdata_a; o.gid = int'(gid_a);
      end
      if (ack_a != '0) begin
        o.ok = 1'b1; o.ack_cyc = cyc; o.ack = 3'(ack_a); o.rdata = rdata_a;
        break;
      end
    end
  endtask

  task automatic wait_b(output obs_t o);
    o = '{default: 0};
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (men_b) begin
        o.men_cnt++; o.men_cyc = cyc; o.madr = maddr_b; o.mwe = mwe_b;
        o.mwd = mwdata_b; o.gid = int'(gid_b);
      end
      if (ack_b != '0) begin
        o.ok = 1'b1; o.ack_cyc = cyc; o.ack = 3'(ack_b); o.rdata = rdata_b;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1;
    req_a = '0; we_a = '0; addr_a = '0; wdata_a = '0;
    req_b = '0; we_b = '0; addr_b = '0; wdata_b = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    n_chk++; if (ack_a !== 2'b00) begin n_fail++; $display("FAIL rst_ack_a: got %b expected 00", ack_a); end
    n_chk++; if (rdata_a !== 32'h0) begin n_fail++; $display("FAIL rst_rdata_a: got %h expected 0", rdata_a); end
    n_chk++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL rst_busy_a: got %b expected 0", busy_a); end
    n_chk++; if (gid_a !== 1'b0) begin n_fail++; $display("FAIL rst_gid_a: got %b expected 0", gid_a); end
    n_chk++; if (men_a !== 1'b0 || mwe_a !== 1'b0) begin n_fail++; $display("FAIL rst_men_a: got en=%b we=%b expected 0 0", men_a, mwe_a); end
    n_chk++; if (maddr_a !== 32'h0 || mwdata_a !== 32'h0) begin n_fail++; $display("FAIL rst_mbus_a: got addr=%h wdata=%h expected 0 0", maddr_a, mwdata_a); end
    n_chk++;
    if ({ack_b, rdata_b, busy_b, gid_b, men_b, mwe_b, maddr_b, mwdata_b} !== '0) begin
      n_fail++; $display("FAIL rst_all_b: got ack=%b rdata=%h busy=%b gid=%0d en=%b expected all zero", ack_b, rdata_b, busy_b, gid_b, men_b);
    end
  endtask

  task automatic test_single_read();
    obs_t o; exp_t e; int c0;
    drive_edge();
    req_a[0] = 1'b1; we_a[0] = 1'b0; addr_a[0*AW +: AW] = 32'h40; c0 = cyc;
    exp_q_a.push_back('{ack: 3'b001, rdata: 32'hDEAD_BEEF, lat: LA + 2, gid: 0});
    wait_a(o);
    n_chk++; if (!o.ok) begin n_fail++; $display("FAIL rd_timeout: got no ack expected ack"); end
    else begin
      e = exp_q_a.pop_front();
      n_chk++; if (o.ack !== e.ack) begin n_fail++; $display("FAIL rd_ack: got %b expected %b", o.ack, e.ack); end
      n_chk++; if (o.rdata !== e.rdata) begin n_fail++; $display("FAIL rd_rdata: got %h expected %h", o.rdata, e.rdata); end
      n_chk++; if (o.ack_cyc - c0 != e.lat) begin n_fail++; $display("FAIL rd_ack_lat: got %0d expected %0d", o.ack_cyc - c0, e.lat); end
      n_chk++; if (o.men_cnt != 1 || o.men_cyc - c0 != 1) begin n_fail++; $display("FAIL rd_men: got cnt=%0d at %0d expected 1 at 1", o.men_cnt, o.men_cyc - c0); end
      n_chk++; if (o.madr !== 32'h40 || o.mwe !== 1'b0) begin n_fail++; $display("FAIL rd_mbus: got addr=%h we=%b expected 40 0", o.madr, o.mwe); end
      n_chk++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL rd_busy_ack: got %b expected 1", busy_a); end
    end
    drive_edge();
    req_a[0] = 1'b0;
    @(negedge clk);
    n_chk++; if (ack_a !== 2'b00 || busy_a !== 1'b0) begin n_fail++; $display("FAIL rd_after: got ack=%b busy=%b expected 00 0", ack_a, busy_a); end
  endtask

  task automatic test_write();
    obs_t o; exp_t e; int c0;
    drive_edge();
    req_a[1] = 1'b1; we_a[1] = 1'b1; addr_a[1*AW +: AW] = 32'h80; wdata_a[1*DW +: DW] = 32'h1234; c0 = cyc;
    exp_q_a.push_back('{ack: 3'b010, rdata: 32'hDEAD_BEEF, lat: LA + 2, gid: 1});
    wait_a(o);
    n_chk++; if (!o.ok) begin n_fail++; $display("FAIL wr_timeout: got no ack expected ack"); end
    else begin
      e = exp_q_a.pop_front();
      n_chk++; if (o.ack !== e.ack) begin n_fail++; $display("FAIL wr_ack: got %b expected %b", o.ack, e.ack); end
      n_chk++; if (o.rdata !== e.rdata) begin n_fail++; $display("FAIL wr_rdata_kept: got %h expected %h", o.rdata, e.rdata); end
      n_chk++; if (o.men_cnt != 1) begin n_fail++; $display("FAIL wr_men_cnt: got %0d expected 1", o.men_cnt); end
      n_chk++; if (o.mwe !== 1'b1 || o.mwd !== 32'h1234 || o.madr !== 32'h80) begin n_fail++; $display("FAIL wr_mbus: got we=%b wd=%h addr=%h expected 1 1234 80", o.mwe, o.mwd, o.madr); end
      n_chk++; if (o.gid != e.gid) begin n_fail++; $display("FAIL wr_gid: got %0d expected %0d", o.gid, e.gid); end
      n_chk++; if (o.ack_cyc - c0 != e.lat) begin n_fail++; $display("FAIL wr_ack_lat: got %0d expected %0d", o.ack_cyc - c0, e.lat); end
    end
    drive_edge();
    req_a[1] = 1'b0; we_a[1] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    obs_t o1, o2; exp_t e; int c0;
    drive_edge();
    req_a[0] = 1'b1; addr_a[0*AW +: AW] = 32'h44; c0 = cyc;
    exp_q_a.push_back('{ack: 3'b001, rdata: mem_fn(32'h44), lat: LA + 2, gid: 0});
    exp_q_a.push_back('{ack: 3'b001, rdata: mem_fn(32'h48), lat: 2*LA + 5, gid: 0});
    wait_a(o1);
    // Present the next request on the edge that ends the ack cycle.
    drive_edge();
    addr_a[0*AW +: AW] = 32'h48;
    wait_a(o2);
    n_chk++; if (!o1.ok || !o2.ok) begin n_fail++; $display("FAIL b2b_timeout: got ok=%0d/%0d expected 1/1", o1.ok, o2.ok); end
    else begin
      e = exp_q_a.pop_front();
      n_chk++; if (o1.rdata !== e.rdata || o1.ack !== e.ack) begin n_fail++; $display("FAIL b2b_first: got %b %h expected %b %h", o1.ack, o1.rdata, e.ack, e.rdata); end
      e = exp_q_a.pop_front();
      n_chk++; if (o2.men_cyc - c0 != LA + 4) begin n_fail++; $display("FAIL b2b_men2: got %0d expected %0d", o2.men_cyc - c0, LA + 4); end
      n_chk++; if (o2.madr !== 32'h48 || o2.gid != e.gid) begin n_fail++; $display("FAIL b2b_mbus2: got addr=%h gid=%0d expected 48 %0d", o2.madr, o2.gid, e.gid); end
      n_chk++; if (o2.rdata !== e.rdata || o2.ack !== e.ack) begin n_fail++; $display("FAIL b2b_second: got %b %h expected %b %h", o2.ack, o2.rdata, e.ack, e.rdata); end
      n_chk++; if (o2.ack_cyc - c0 != e.lat) begin n_fail++; $display("FAIL b2b_ack_lat: got %0d expected %0d", o2.ack_cyc - c0, e.lat); end
    end
    drive_edge();
    req_a[0] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    obs_t o; exp_t e; int c0;
    drive_edge();
    for (int i = 0; i < NB; i++) addr_b[i*AW +: AW] = 32'h100 + 32'(i*4);
    req_b = '1; we_b = '0; c0 = cyc;
    for (int k = 0; k < 6; k++) begin
      exp_q_b.push_back('{ack: 3'(3'b001 << (k % 3)), rdata: mem_fn(32'h100 + 32'((k % 3)*4)),
                          lat: LB + 2 + k*(LB + 3), gid: k % 3});
    end
    for (int k = 0; k < 6; k++) begin
      wait_b(o);
      n_chk++; if (!o.ok || exp_q_b.size() == 0) begin n_fail++; $display("FAIL rr_timeout: got no ack at grant %0d expected ack", k); break; end
      e = exp_q_b.pop_front();
      n_chk++; if (o.ack !== e.ack) begin n_fail++; $display("FAIL rr_ack: got %b expected %b at grant %0d", o.ack, e.ack, k); end
      n_chk++; if (o.gid != e.gid || o.men_cnt != 1) begin n_fail++; $display("FAIL rr_gid: got %0d men=%0d expected %0d men=1", o.gid, o.men_cnt, e.gid); end
      n_chk++; if (o.rdata !== e.rdata) begin n_fail++; $display("FAIL rr_rdata: got %h expected %h", o.rdata, e.rdata); end
      n_chk++; if (o.ack_cyc - c0 != e.lat) begin n_fail++; $display("FAIL rr_lat: got %0d expected %0d", o.ack_cyc - c0, e.lat); end
    end
    drive_edge();
    req_b = '0;
    @(negedge clk);
  endtask

  task automatic test_latency_sweep();
    obs_t o; exp_t e; int c0;
    drive_edge();
    req_b[0] = 1'b1; addr_b[0*AW +: AW] = 32'h200; c0 = cyc;
    exp_q_b.push_back('{ack: 3'b001, rdata: mem_fn(32'h200), lat: 6, gid: 0});
    wait_b(o);
    n_chk++; if (!o.ok) begin n_fail++; $display("FAIL lat_timeout: got no ack expected ack"); end
    else begin
      e = exp_q_b.pop_front();
      n_chk++; if (o.ack_cyc - c0 != e.lat) begin n_fail++; $display("FAIL lat_ack: got %0d expected %0d", o.ack_cyc - c0, e.lat); end
      n_chk++; if (o.men_cnt != 1 || o.men_cyc - c0 != 1) begin n_fail++; $display("FAIL lat_men: got cnt=%0d at %0d expected 1 at 1", o.men_cnt, o.men_cyc - c0); end
      n_chk++; if (o.rdata !== e.rdata || o.ack !== e.ack) begin n_fail++; $display("FAIL lat_data: got %b %h expected %b %h", o.ack, o.rdata, e.ack, e.rdata); end
    end
    drive_edge();
    req_b[0] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    obs_t o; exp_t e;
    drive_edge();
    req_a[1] = 1'b1; we_a[1] = 1'b0; addr_a[1*AW +: AW] = 32'h90;
    @(negedge clk);
    @(negedge clk);
    n_chk++; if (men_a !== 1'b1 || gid_a !== 1'b1) begin n_fail++; $display("FAIL rm_start: got en=%b gid=%b expected 1 1", men_a, gid_a); end
    drive_edge();
    rst_a = 1'b1;
    @(negedge clk);
    n_chk++; if (ack_a !== 2'b00) begin n_fail++; $display("FAIL rm_wait_ack: got %b expected 00", ack_a); end
    drive_edge();
    rst_a = 1'b0;
    req_a[0] = 1'b1; we_a[0] = 1'b0; addr_a[0*AW +: AW] = 32'h50;
    exp_q_a.push_back('{ack: 3'b001, rdata: mem_fn(32'h50), lat: 0, gid: 0});
    exp_q_a.push_back('{ack: 3'b010, rdata: mem_fn(32'h90), lat: 0, gid: 1});
    @(negedge clk);
    n_chk++;
    if ({ack_a, rdata_a, busy_a, gid_a, men_a, mwe_a, maddr_a, mwdata_a} !== '0) begin
      n_fail++; $display("FAIL rm_reset_vals: got ack=%b rdata=%h busy=%b gid=%b en=%b addr=%h expected all zero", ack_a, rdata_a, busy_a, gid_a, men_a, maddr_a);
    end
    for (int k = 0; k < 2; k++) begin
      wait_a(o);
      n_chk++; if (!o.ok || exp_q_a.size() == 0) begin n_fail++; $display("FAIL rm_timeout: got no ack at %0d expected ack", k); break; end
      e = exp_q_a.pop_front();
      n_chk++; if (o.ack !== e.ack || o.gid != e.gid) begin n_fail++; $display("FAIL rm_order: got %b gid=%0d expected %b gid=%0d", o.ack, o.gid, e.ack, e.gid); end
      n_chk++; if (o.rdata !== e.rdata) begin n_fail++; $display("FAIL rm_rdata: got %h expected %h", o.rdata, e.rdata); end
      drive_edge();
      if (k == 0) req_a[0] = 1'b0;
      else        req_a[1] = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_back_to_back();
    test_round_robin();
    test_latency_sweep();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
